audio_sample_packetizer: RTL



---
 rtl/audio_sample_packetizer.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/audio_sample_packetizer.sv
// HDMI Audio Sample Packet builder: stereo PCM FIFO plus a fixed-latency packet assembler.
// Optional feature: define HDMI_AUDIO_CHSTAT_EN to send CHSTAT bits as per-frame channel status.
module audio_sample_packetizer #(
    parameter int          SAMPLE_WIDTH = 16,
    parameter int          FIFO_DEPTH   = 8,
    parameter logic [39:0] CHSTAT       = 40'h0000000004
) (
    input  logic                          clk_pixel,
    input  logic                          reset,
    input  logic                          sample_valid,
    output logic                          sample_ready,
    input  logic [SAMPLE_WIDTH-1:0]       sample_left,
    input  logic [SAMPLE_WIDTH-1:0]       sample_right,
    input  logic                          packet_request,
    output logic                          packet_valid,
    output logic [23:0]                   header,
    output logic [55:0]                   sub0,
    output logic [55:0]                   sub1,
    output logic [55:0]                   sub2,
    output logic [55:0]                   sub3,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int SHIFT = 24 - SAMPLE_WIDTH;

    typedef enum logic [1:0] {IDLE, POP, EMIT} state_t;

    state_t state;
    state_t state_next;

    logic [2*SAMPLE_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]             wr_ptr;
    logic [AW-1:0]             rd_ptr;
    logic                      push;
    logic                      pop;

    logic [1:0]  k;
    logic [2:0]  n;
    logic [7:0]  frame;
    logic [3:0]  present;
    logic [55:0] work0;
    logic [55:0] work1;
    logic [55:0] work2;
    logic [2:0]  work_b;

    logic [SAMPLE_WIDTH-1:0] head_left;
    logic [SAMPLE_WIDTH-1:0] head_right;
    logic [23:0]             l24;
    logic [23:0]             r24;
    logic                    chan_c;
    logic                    p_l;
    logic                    p_r;
    logic [55:0]             built;
    logic [55:0]             fill;
    logic                    first_frame;

    // Sample handshake: a pair transfers on a rising edge where sample_valid && sample_ready;
    // sample_ready depends only on the stored level, never on a same-cycle pop.
    assign sample_ready = !reset && (fifo_level < (AW+1)'(FIFO_DEPTH));
    assign push         = sample_valid && sample_ready;
    assign pop          = (state == POP) && ({1'b0, k} < n);

    always_ff @(posedge clk_pixel) begin
        if (push) begin
            mem[wr_ptr] <= {sample_left, sample_right};
        end
    end

    always_ff @(posedge clk_pixel or posedge reset) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   fifo_level <= fifo_level + 1'b1;
                2'b01:   fifo_level <= fifo_level - 1'b1;
                default: fifo_level <= fifo_level;
            endcase
        end
    end

    assign head_left  = mem[rd_ptr][2*SAMPLE_WIDTH-1:SAMPLE_WIDTH];
    assign head_right = mem[rd_ptr][SAMPLE_WIDTH-1:0];
    assign l24        = 24'(head_left) << SHIFT;
    assign r24        = 24'(head_right) << SHIFT;

`ifdef HDMI_AUDIO_CHSTAT_EN
    logic [39:0] chstat_bits;
    assign chstat_bits = CHSTAT;
    assign chan_c      = (frame < 8'd40) ? chstat_bits[frame[5:0]] : 1'b0;
`else
    logic unused_chstat;
    assign unused_chstat = ^CHSTAT;
    assign chan_c        = 1'b0;
`endif

    // V and U are always zero, so parity covers the sample and C only.
    assign p_l         = ^{l24, 1'b0, 1'b0, chan_c};
    assign p_r         = ^{r24, 1'b0, 1'b0, chan_c};
    assign built       = {p_r, chan_c, 1'b0, 1'b0, p_l, chan_c, 1'b0, 1'b0, r24, l24};
    assign fill        = pop ? built : 56'd0;
    assign first_frame = pop && (frame == 8'd0);

    always_comb begin
        present = 4'b0000;
        case (n)
            3'd0:    present = 4'b0000;
            3'd1:    present = 4'b0001;
            3'd2:    present = 4'b0011;
            3'd3:    present = 4'b0111;
            default: present = 4'b1111;
        endcase
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (packet_request) state_next = POP;
            POP:     if (k == 2'd3) state_next = EMIT;
            EMIT:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_pixel or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            k     <= '0;
            n     <= '0;
            frame <= '0;
        end else begin
            state <= state_next;
            if (state == IDLE) begin
                k <= '0;
                if (packet_request) begin
                    n <= (fifo_level >= (AW+1)'(4)) ? 3'd4 : fifo_level[2:0];
                end
            end else if (state == POP) begin
                k <= k + 1'b1;
            end
            if (pop) begin
                frame <= (frame == 8'd191) ? 8'd0 : frame + 8'd1;
            end
        end
    end

    // The last POP cycle writes its subpacket straight into the outputs alongside packet_valid.
    always_ff @(posedge clk_pixel or posedge reset) begin
        if (reset) begin
            work0        <= '0;
            work1        <= '0;
            work2        <= '0;
            work_b       <= '0;
            packet_valid <= 1'b0;
            header       <= '0;
            sub0         <= '0;
            sub1         <= '0;
            sub2         <= '0;
            sub3         <= '0;
        end else begin
            packet_valid <= 1'b0;
            if (state == POP) begin
                case (k)
                    2'd0: begin
                        work0     <= fill;
                        work_b[0] <= first_frame;
                    end
                    2'd1: begin
                        work1     <= fill;
                        work_b[1] <= first_frame;
                    end
                    2'd2: begin
                        work2     <= fill;
                        work_b[2] <= first_frame;
                    end
                    default: begin
                        sub0         <= work0;
                        sub1         <= work1;
                        sub2         <= work2;
                        sub3         <= fill;
                        header       <= {4'b0000, first_frame, work_b, 4'b0000, present, 8'h02};
                        packet_valid <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule
